dsp_mac_pipe: RTL and testbench
===============================

// Module: dsp_mac_pipe
// PURPOSE
//  Parametrised, behavioural 3-stage multiply-accumulate pipeline: next generation of the fixed DSP48E1 multiply slice.
//  Adds valid/ready flow control, run-time op mode, accumulate-chain framing, overflow detection and optional saturation.
//  Sits between sample sources and filter/accumulate consumers; all arithmetic is in fabric/inferred DSP, no primitive instantiated.
// PARAMETERS
//  A_W      25  width of operand a
//  B_W      18  width of operand b
//  P_W      48  width of accumulator/result; P_W >= A_W+B_W is required (elaboration error otherwise)
//  SIGNED    1  1: two's-complement operands/result; 0: unsigned
//  SATURATE  0  1: clamp on overflow; 0: wrap modulo 2**P_W
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         block accepts beat this cycle
//  in_a       in   A_W       multiplicand
//  in_b       in   B_W       multiplier
//  in_c       in   P_W       addend (mode ADDC only)
//  in_mode    in   2         00 MULT, 01 MAC, 10 MSUB, 11 ADDC
//  in_first   in   1         beat starts chain: accumulator operand taken as 0
//  in_last    in   1         beat ends chain: MAC/MSUB result is emitted
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  out_p      out  P_W       result
//  out_ovf    out  1         overflow occurred in this result's chain
// BEHAVIOUR
//  Reset: all stage valids 0, accumulator 0, out_p 0, out_ovf 0, out_valid 0; in_ready 1 on first cycle after release.
//  Reset mid-operation discards all in-flight beats and the accumulator; no partial output is produced.
//  Stages: S1 registers a,b,c,mode,first,last; S2 registers product a*b (A_W+B_W, sign/zero-extended to P_W);
//   S3 = accumulator register (drives out_p).
//  Advance: adv = !out_valid | out_ready; whole pipeline (incl. bubbles) moves only when adv; in_ready = adv.
//  Beat accepted when in_valid & in_ready. Latency accept->out_valid = 3 cycles with no stall.
//  S3 update when beat moves S2->S3, acc_op = first ? 0 : acc:
//   MULT: acc <= prod            ADDC: acc <= in_c + prod
//   MAC:  acc <= acc_op + prod   MSUB: acc <= acc_op - prod
//  Every beat updates acc (MULT/ADDC overwrite it; a following MAC without first accumulates onto it).
//  Emit: out_valid <= 1 for MULT/ADDC always; for MAC/MSUB only when last. Non-emitting beats leave out_valid 0.
//  out_valid held with stable out_p/out_ovf until out_ready; then cleared unless a new emitting beat lands same cycle.
//  Overflow: SIGNED=1 -> signed overflow of P_W add/sub; SIGNED=0 -> carry out (add) or borrow (sub).
//  SATURATE=1: result clamps to max (2**(P_W-1)-1 signed / all-ones unsigned) or min (-2**(P_W-1) / 0); chain continues from clamp.
//  out_ovf: sticky over chain; cleared by first or by MULT/ADDC beat (their own overflow only); reported with emitted result.
//  in_first & in_last same beat: single-beat chain, emits acc = +/-prod.
//  No combinational path from in_valid to any output; in_ready depends only on out_valid and out_ready.
// TESTING
//  1 MULT, SIGNED=1: a=-3, b=7 -> out_p=48'hFFFF_FFFF_FFEB, out_valid 3 cycles after accept, out_ovf=0.
//  2 MAC chain a=1,2,3,4 b=10, first on beat1, last on beat4 -> exactly one out_valid, out_p=100.
//  3 Back-to-back MULT stream, out_ready low 5 cycles -> in_ready low same cycles, no loss/duplication, order preserved.
//  4 A_W=8,B_W=8,P_W=16: MAC 127*127 x3 (first/last) -> SATURATE=1: 16'h7FFF ovf=1; SATURATE=0: 16'hBD03 ovf=1.
//  5 ADDC c=48'h95514, a=2, b=3 -> out_p=48'h9551A; MSUB first/last a=5,b=5 -> out_p=-25.
//  6 rst_n low after 2 beats of a chain -> out_valid 0, out_p 0; new chain a=2,b=2 first/last -> out_p=4.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 3-stage multiply-accumulate pipeline with flow control, chain framing and overflow handling
// S1 registers operands, S2 registers the extended product, S3 is the accumulator that drives out_p.
module dsp_mac_pipe #(
  parameter int A_W      = 25,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic [P_W-1:0] in_c,
  input  logic [1:0]     in_mode,
  input  logic           in_first,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_p,
  output logic           out_ovf
);

  localparam int M_W = A_W + B_W;

  typedef enum logic [1:0] {
    MODE_MULT = 2'b00,
    MODE_MAC  = 2'b01,
    MODE_MSUB = 2'b10,
    MODE_ADDC = 2'b11
  } mode_t;

  generate
    if (P_W < M_W) begin : g_width_check
      $error("dsp_mac_pipe: P_W must be >= A_W + B_W");
    end
  endgenerate

  logic adv;

  // The whole pipeline, bubbles included, moves in lockstep with the output register.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: operand capture ----------------
  logic           s1_valid;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic [P_W-1:0] s1_c;
  mode_t          s1_mode;
  logic           s1_first;
  logic           s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_mode  <= MODE_MULT;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_c     <= in_c;
        s1_mode  <= mode_t'(in_mode);
        s1_first <= in_first;
        s1_last  <= in_last;
      end
    end
  end

  // ---------------- stage 2: product ----------------
  logic           a_ext_bit;
  logic           b_ext_bit;
  logic [M_W-1:0] mul_a;
  logic [M_W-1:0] mul_b;
  logic [M_W-1:0] prod_raw;
  logic [P_W-1:0] prod_ext;

  // Operands are pre-extended to the full product width so the low M_W bits are exact either signedness.
  assign a_ext_bit = (SIGNED != 0) ? s1_a[A_W-1] : 1'b0;
  assign b_ext_bit = (SIGNED != 0) ? s1_b[B_W-1] : 1'b0;
  assign mul_a     = {{B_W{a_ext_bit}}, s1_a};
  assign mul_b     = {{A_W{b_ext_bit}}, s1_b};
  assign prod_raw  = mul_a * mul_b;

  generate
    if (P_W > M_W) begin : g_prod_ext
      logic prod_ext_bit;
      assign prod_ext_bit = (SIGNED != 0) ? prod_raw[M_W-1] : 1'b0;
      assign prod_ext     = {{(P_W-M_W){prod_ext_bit}}, prod_raw};
    end else begin : g_prod_same
      assign prod_ext = prod_raw;
    end
  endgenerate

  logic           s2_valid;
  logic [P_W-1:0] s2_prod;
  logic [P_W-1:0] s2_c;
  mode_t          s2_mode;
  logic           s2_first;
  logic           s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_c     <= '0;
      s2_mode  <= MODE_MULT;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= prod_ext;
        s2_c     <= s1_c;
        s2_mode  <= s1_mode;
        s2_first <= s1_first;
        s2_last  <= s1_last;
      end
    end
  end

  // ---------------- stage 3: accumulate ----------------
  logic [P_W-1:0] acc;
  logic [P_W-1:0] acc_op;
  logic [P_W-1:0] op_x;
  logic           op_sub;
  logic [P_W:0]   sum_ext;
  logic [P_W-1:0] sum_raw;
  logic           ovf_signed;
  logic           ovf_unsigned;
  logic           beat_ovf;
  logic [P_W-1:0] sat_val;
  logic [P_W-1:0] acc_next;
  logic           chain_start;
  logic           emit;
  logic           ovf_next;

  assign acc_op = s2_first ? '0 : acc;

  always_comb begin
    op_x   = '0;
    op_sub = 1'b0;
    case (s2_mode)
      MODE_MULT: op_x = '0;
      MODE_MAC:  op_x = acc_op;
      MODE_MSUB: begin
        op_x   = acc_op;
        op_sub = 1'b1;
      end
      MODE_ADDC: op_x = s2_c;
      default:   op_x = '0;
    endcase
  end

  // One extra bit captures carry (add) or borrow (sub) for the unsigned overflow case.
  assign sum_ext = op_sub ? ({1'b0, op_x} - {1'b0, s2_prod})
                          : ({1'b0, op_x} + {1'b0, s2_prod});
  assign sum_raw = sum_ext[P_W-1:0];

  assign ovf_signed = op_sub
    ? ((op_x[P_W-1] != s2_prod[P_W-1]) && (sum_raw[P_W-1] != op_x[P_W-1]))
    : ((op_x[P_W-1] == s2_prod[P_W-1]) && (sum_raw[P_W-1] != op_x[P_W-1]));
  assign ovf_unsigned = sum_ext[P_W];
  assign beat_ovf     = (SIGNED != 0) ? ovf_signed : ovf_unsigned;

  // Signed overflow always pushes away from the sign of op_x, so that sign picks the rail.
  always_comb begin
    sat_val = '0;
    if (SIGNED != 0) begin
      if (op_x[P_W-1]) sat_val = {1'b1, {(P_W-1){1'b0}}};
      else             sat_val = {1'b0, {(P_W-1){1'b1}}};
    end else begin
      sat_val = op_sub ? '0 : '1;
    end
  end

  assign acc_next    = ((SATURATE != 0) && beat_ovf) ? sat_val : sum_raw;
  assign chain_start = s2_first || (s2_mode == MODE_MULT) || (s2_mode == MODE_ADDC);
  assign emit        = (s2_mode == MODE_MULT) || (s2_mode == MODE_ADDC) || s2_last;
  assign ovf_next    = beat_ovf || (!chain_start && out_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (s2_valid) begin
        acc       <= acc_next;
        out_ovf   <= ovf_next;
        out_valid <= emit;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_p = acc;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed-vector bench for dsp_mac_pipe (default and 8x8->16 saturating/wrapping builds)
module tb_dsp_mac_pipe;

  localparam logic [1:0] M_MULT = 2'b00;
  localparam logic [1:0] M_MAC  = 2'b01;
  localparam logic [1:0] M_MSUB = 2'b10;
  localparam logic [1:0] M_ADDC = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid, in_first, in_last, out_ready;
  logic [24:0] in_a;
  logic [17:0] in_b;
  logic [47:0] in_c;
  logic [1:0]  in_mode;
  logic        in_ready, out_valid, out_ovf;
  logic [47:0] out_p;

  logic        s_valid, s_first, s_last, s_out_ready;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_c;
  logic [1:0]  s_mode;
  logic        sat_in_ready, sat_out_valid, sat_ovf;
  logic [15:0] sat_p;
  logic        wrp_in_ready, wrp_out_valid, wrp_ovf;
  logic [15:0] wrp_p;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_ovf(out_ovf)
  );

  dsp_mac_pipe #(.A_W(8), .B_W(8), .P_W(16), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(sat_in_ready),
    .in_a(s_a), .in_b(s_b), .in_c(s_c), .in_mode(s_mode),
    .in_first(s_first), .in_last(s_last),
    .out_valid(sat_out_valid), .out_ready(s_out_ready),
    .out_p(sat_p), .out_ovf(sat_ovf)
  );

  dsp_mac_pipe #(.A_W(8), .B_W(8), .P_W(16), .SIGNED(1), .SATURATE(0)) u_wrp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(wrp_in_ready),
    .in_a(s_a), .in_b(s_b), .in_c(s_c), .in_mode(s_mode),
    .in_first(s_first), .in_last(s_last),
    .out_valid(wrp_out_valid), .out_ready(s_out_ready),
    .out_p(wrp_p), .out_ovf(wrp_ovf)
  );

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic drive_beat(input logic [24:0] a, input logic [17:0] b, input logic [47:0] c,
                            input logic [1:0] mode, input logic first, input logic last);
    logic took;
    in_a = a; in_b = b; in_c = c; in_mode = mode; in_first = first; in_last = last;
    in_valid = 1'b1;
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      #1 took = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    nvec++;
    if (!took) begin nerr++; $display("FAIL drive_timeout got in_ready=0 want 1"); end
  endtask

  task automatic drive_small(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                             input logic first, input logic last);
    logic took;
    s_a = a; s_b = b; s_c = '0; s_mode = mode; s_first = first; s_last = last;
    s_valid = 1'b1;
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      #1 took = sat_in_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    nvec++;
    if (!took) begin nerr++; $display("FAIL drive_small_timeout got in_ready=0 want 1"); end
  endtask

  task automatic collect(input int ncyc, output int cnt, output logic [47:0] p0, output logic o0,
                         output logic [47:0] p1, output logic o1);
    cnt = 0; p0 = '0; o0 = 1'b0; p1 = '0; o1 = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      if (out_valid) begin
        if (cnt == 0) begin p0 = out_p; o0 = out_ovf; end
        else if (cnt == 1) begin p1 = out_p; o1 = out_ovf; end
        cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic collect_small(output int scnt, output logic [15:0] sp, output logic so,
                               output int wcnt, output logic [15:0] wp, output logic wo);
    scnt = 0; sp = '0; so = 1'b0; wcnt = 0; wp = '0; wo = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (sat_out_valid) begin sp = sat_p; so = sat_ovf; scnt++; end
      if (wrp_out_valid) begin wp = wrp_p; wo = wrp_ovf; wcnt++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (out_p !== 48'h0) begin nerr++; $display("FAIL reset_out_p got %h want 0", out_p); end
    nvec++; if (out_ovf !== 1'b0) begin nerr++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({in_ready, sat_in_ready, wrp_in_ready} !== 3'b111) begin
      nerr++; $display("FAIL reset_in_ready got %b want 111", {in_ready, sat_in_ready, wrp_in_ready});
    end
  endtask

  task automatic test_mult;
    int lat;
    drive_beat(-25'sd3, 18'sd7, '0, M_MULT, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    nvec++; if (lat != 3) begin nerr++; $display("FAIL mult_latency got %0d want 3", lat); end
    nvec++; if (out_p !== 48'hFFFF_FFFF_FFEB) begin nerr++; $display("FAIL mult_p got %h want ffffffffffeb", out_p); end
    nvec++; if (out_ovf !== 1'b0) begin nerr++; $display("FAIL mult_ovf got %b want 0", out_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_mac_chain;
    int cnt; logic [47:0] p0, p1; logic o0, o1;
    drive_beat(25'd1, 18'd10, '0, M_MAC, 1'b1, 1'b0);
    drive_beat(25'd2, 18'd10, '0, M_MAC, 1'b0, 1'b0);
    drive_beat(25'd3, 18'd10, '0, M_MAC, 1'b0, 1'b0);
    drive_beat(25'd4, 18'd10, '0, M_MAC, 1'b0, 1'b1);
    collect(8, cnt, p0, o0, p1, o1);
    nvec++; if (cnt != 1) begin nerr++; $display("FAIL mac_count got %0d want 1", cnt); end
    nvec++; if (p0 !== 48'd100) begin nerr++; $display("FAIL mac_p got %0d want 100", p0); end
    nvec++; if (o0 !== 1'b0) begin nerr++; $display("FAIL mac_ovf got %b want 0", o0); end
  endtask

  task automatic test_mac_after_mult;
    int cnt; logic [47:0] p0, p1; logic o0, o1;
    drive_beat(25'd3, 18'd4, '0, M_MULT, 1'b0, 1'b0);
    drive_beat(25'd2, 18'd5, '0, M_MAC, 1'b0, 1'b1);
    collect(8, cnt, p0, o0, p1, o1);
    nvec++; if (cnt != 2) begin nerr++; $display("FAIL mult_mac_count got %0d want 2", cnt); end
    nvec++; if (p0 !== 48'd12) begin nerr++; $display("FAIL mult_mac_p0 got %0d want 12", p0); end
    nvec++; if (p1 !== 48'd22) begin nerr++; $display("FAIL mult_mac_p1 got %0d want 22", p1); end
  endtask

  task automatic test_back_to_back;
    int sent, recv;
    logic signed [47:0] exp_p;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid = (sent < 8);
      in_a = 25'(sent + 1); in_b = 18'h3FFFE; in_c = '0;
      in_mode = M_MULT; in_first = 1'b0; in_last = 1'b0;
      #1;
      if (!out_ready) begin
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_stall_in_ready cyc %0d got %b want 0", cyc, in_ready); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        exp_p = -2 * (recv + 1);
        nvec++;
        if (out_p !== exp_p) begin nerr++; $display("FAIL b2b_order idx %0d got %h want %h", recv, out_p, exp_p); end
        recv++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    nvec++; if (recv != 8) begin nerr++; $display("FAIL b2b_received got %0d want 8", recv); end
    for (int n = 0; n < 5; n++) begin
      if (out_valid) recv++;
      @(posedge clk); #1;
    end
    nvec++; if (recv != 8) begin nerr++; $display("FAIL b2b_duplicate got %0d want 8", recv); end
  endtask

  task automatic test_addc_msub;
    int cnt; logic [47:0] p0, p1; logic o0, o1;
    drive_beat(25'd2, 18'd3, 48'h95514, M_ADDC, 1'b0, 1'b0);
    drive_beat(25'd5, 18'd5, '0, M_MSUB, 1'b1, 1'b1);
    collect(8, cnt, p0, o0, p1, o1);
    nvec++; if (cnt != 2) begin nerr++; $display("FAIL addc_msub_count got %0d want 2", cnt); end
    nvec++; if (p0 !== 48'h9551A) begin nerr++; $display("FAIL addc_p got %h want 9551a", p0); end
    nvec++; if (p1 !== 48'hFFFF_FFFF_FFE7) begin nerr++; $display("FAIL msub_p got %h want ffffffffffe7", p1); end
    nvec++; if ({o0, o1} !== 2'b00) begin nerr++; $display("FAIL addc_msub_ovf got %b want 00", {o0, o1}); end
  endtask

  task automatic test_saturate;
    int sc, wc; logic [15:0] sp, wp; logic so, wo;
    drive_small(8'd127, 8'd127, M_MAC, 1'b1, 1'b0);
    drive_small(8'd127, 8'd127, M_MAC, 1'b0, 1'b0);
    drive_small(8'd127, 8'd127, M_MAC, 1'b0, 1'b1);
    collect_small(sc, sp, so, wc, wp, wo);
    nvec++; if (sc != 1 || wc != 1) begin nerr++; $display("FAIL sat_mac_count got %0d/%0d want 1/1", sc, wc); end
    nvec++; if (sp !== 16'h7FFF || so !== 1'b1) begin nerr++; $display("FAIL sat_mac_p got %h ovf %b want 7fff ovf 1", sp, so); end
    nvec++; if (wp !== 16'hBD03 || wo !== 1'b1) begin nerr++; $display("FAIL wrap_mac_p got %h ovf %b want bd03 ovf 1", wp, wo); end
    drive_small(8'd127, 8'd127, M_MSUB, 1'b1, 1'b0);
    drive_small(8'd127, 8'd127, M_MSUB, 1'b0, 1'b0);
    drive_small(8'd127, 8'd127, M_MSUB, 1'b0, 1'b1);
    collect_small(sc, sp, so, wc, wp, wo);
    nvec++; if (sp !== 16'h8000 || so !== 1'b1) begin nerr++; $display("FAIL sat_msub_p got %h ovf %b want 8000 ovf 1", sp, so); end
    nvec++; if (wp !== 16'h42FD || wo !== 1'b1) begin nerr++; $display("FAIL wrap_msub_p got %h ovf %b want 42fd ovf 1", wp, wo); end
    drive_small(8'd2, 8'd3, M_MULT, 1'b0, 1'b0);
    collect_small(sc, sp, so, wc, wp, wo);
    nvec++; if (sp !== 16'd6 || so !== 1'b0) begin nerr++; $display("FAIL sat_ovf_clear got %h ovf %b want 0006 ovf 0", sp, so); end
  endtask

  task automatic test_reset_mid;
    int cnt; logic [47:0] p0, p1; logic o0, o1;
    drive_beat(25'd7, 18'd7, '0, M_MAC, 1'b1, 1'b0);
    drive_beat(25'd1, 18'd1, '0, M_MAC, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0 || out_p !== 48'h0) begin nerr++; $display("FAIL midreset_state got v=%b p=%h want v=0 p=0", out_valid, out_p); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(25'd2, 18'd2, '0, M_MAC, 1'b1, 1'b1);
    collect(8, cnt, p0, o0, p1, o1);
    nvec++; if (cnt != 1) begin nerr++; $display("FAIL midreset_count got %0d want 1", cnt); end
    nvec++; if (p0 !== 48'd4 || o0 !== 1'b0) begin nerr++; $display("FAIL midreset_p got %h ovf %b want 4 ovf 0", p0, o0); end
  endtask

  initial begin
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_mode = M_MULT;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_out_ready = 1'b1;
    s_a = '0; s_b = '0; s_c = '0; s_mode = M_MULT;
    test_reset();
    test_mult();
    test_mac_chain();
    test_mac_after_mult();
    test_back_to_back();
    test_addc_msub();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
